sdr_cmd_receive: RTL and testbench
==================================

# sdr_cmd_receive

Parametrised successor to the protocol-2 port-1024 command receiver. Parses HPSDR command packets byte-by-byte from the UDP receive stream: discovery, set-IP and remote FPGA reconfigure. Adds sequence-number checking with a real `seq_error`, packet/error counters, a qualified set-IP commit and a parametrised ACK timeout. Sits between the UDP RX layer and `sdr_send`/EEPROM/reconfig logic in the `rx_clock` domain.

## Interface
- `PORT`, 1024, UDP destination port accepted
- `ACK_W`, 27, width of discovery ACK timeout counter; timeout = 2^ACK_W−1 cycles
- `RESET_CMD_EN`, 1, 1 enables command 6 (nconfig)
- `SEQ_CHECK_EN`, 1, 1 enables sequence checking
- `rx_clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `udp_rx_data`  in  8  payload byte, valid each cycle `udp_rx_active`=1
- `udp_rx_active`  in  1  high for whole payload
- `to_port`  in  16  destination port of current packet
- `broadcast`  in  1  packet was broadcast
- `local_mac`  in  48  this board's MAC
- `sending_sync`  in  1  `sdr_send` busy transmitting reply
- `discovery_ACK`  in  1  `sdr_send` accepted discovery request
- `discovery_reply`  out  1  discovery request to `sdr_send`
- `sequence_number`  out  32  sequence number of last accepted packet
- `seq_error`  out  1  one-cycle pulse on sequence mismatch
- `set_ip`  out  1  sticky: new static IP valid
- `assign_ip`  out  32  committed static IP
- `nconfig`  out  1  sticky: reconfigure FPGA
- `pkt_count`  out  16  accepted packets, wraps
- `err_count`  out  16  sequence errors, saturates at 0xFFFF

## Operation
- Reset: all outputs 0; state IDLE; `seq_valid`=0.
- Packet accepted when `udp_rx_active`=1 and `to_port`==PORT; otherwise state forced to IDLE each cycle. Byte index b counts from 0.
- States: IDLE, SEQ, CMD, DISCOVERY, TX, SETIP, RESET, WAIT.
- IDLE: b0 → seq[31:24]; go SEQ. SEQ: b1..b3 → seq[23:0]; after b3 go CMD.
- CMD (b4): `sequence_number`←seq; `pkt_count`+1. If SEQ_CHECK_EN and `seq_valid` and seq ≠ prev+1 (32-bit wrap, 0xFFFFFFFF→0 is legal): pulse `seq_error`, `err_count`+1. prev←seq, `seq_valid`←1 regardless. Command decode: 2 → DISCOVERY; 3 and `broadcast` → SETIP; 6 and !`broadcast` and RESET_CMD_EN → RESET; all else → WAIT. Commands 4/5 (erase/program) are WAIT.
- DISCOVERY: one cycle, → TX. TX: → IDLE when !`sending_sync`.
- SETIP: b5..b10 MAC, b11..b14 shadow IP. At b11, MAC ≠ `local_mac` → WAIT. After b14: `assign_ip`←shadow, `set_ip`←1, → WAIT. Packet ending before b14: nothing committed.
- RESET: `nconfig`←1, held until reset.
- WAIT: hold until `udp_rx_active` drops (forced IDLE).
- Discovery handshake (independent FSM, runs regardless of `udp_rx_active`): on state==DISCOVERY and handshake idle, `discovery_reply`←1, timer←1. Then clear `discovery_reply` when `discovery_ACK`=1 or timer==0; else timer+1. DISCOVERY entered while pending: ignored, no second request.
- `set_ip` stays high; a later valid set-IP overwrites `assign_ip`.

## Timing
- Command byte on edge N → `seq_error` high after edge N (one cycle); state DISCOVERY after N; `discovery_reply` high after N+1.
- `discovery_ACK` sampled high at edge M → `discovery_reply` low after M. Without ACK, low 2^ACK_W−1 cycles after rising.
- b14 on edge N → `set_ip`, `assign_ip` valid after N.
- `udp_rx_active` low at edge N → state IDLE after N, from any state.
- `reset_n` low: immediate clear of all outputs and handshake, mid-packet included; rest of that packet parsed from IDLE only once `udp_rx_active` falls and rises again.

## Test plan
- Seq 0x00000005 cmd 2 unicast; ACK 3 cycles after `discovery_reply` rises -> reply high 3 cycles, `pkt_count`=1, no `seq_error`.
- ACK_W=4, cmd 2, ACK never -> `discovery_reply` high exactly 15 cycles; second cmd 2 during pending issues no new request.
- Seqs 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000005 -> one `seq_error` pulse (last), `err_count`=1, `pkt_count`=4.
- Broadcast cmd 3, MAC = `local_mac`, IP C0A8_0164 -> `set_ip`=1, `assign_ip`=0xC0A80164; wrong MAC or packet ending at b12 -> `set_ip`=0.
- Cmd 6 broadcast -> `nconfig`=0; cmd 6 unicast -> `nconfig`=1; `to_port`=1025 any packet -> no output change.
- `reset_n` pulsed during SETIP b12 -> all outputs 0; next packet seq 9 -> no `seq_error` (first after reset).

Source files
------------

// File: rtl/sdr_cmd_receive.sv
// HPSDR protocol-2 command receiver: parses discovery, set-IP and reconfigure
// packets from the UDP RX byte stream, with sequence checking and counters.
module sdr_cmd_receive #(
    parameter logic [15:0] PORT         = 16'd1024,
    parameter int          ACK_W        = 27,
    parameter bit          RESET_CMD_EN = 1'b1,
    parameter bit          SEQ_CHECK_EN = 1'b1
) (
    input  logic        rx_clock,
    input  logic        reset_n,
    input  logic [7:0]  udp_rx_data,
    input  logic        udp_rx_active,
    input  logic [15:0] to_port,
    input  logic        broadcast,
    input  logic [47:0] local_mac,
    input  logic        sending_sync,
    input  logic        discovery_ACK,
    output logic        discovery_reply,
    output logic [31:0] sequence_number,
    output logic        seq_error,
    output logic        set_ip,
    output logic [31:0] assign_ip,
    output logic        nconfig,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {
        IDLE, SEQ, CMD, DISCOVERY, TX, SETIP, RESET, WAIT
    } state_t;

    state_t             state;
    logic [3:0]         byte_idx;
    logic [31:0]        seq_sh;
    logic [47:0]        mac_sh;
    logic [23:0]        ip_sh;
    logic               seq_valid;
    logic               armed;
    logic [ACK_W-1:0]   timer;

    logic               accept;
    logic [ACK_W-1:0]   timer_inc;

    assign accept    = udp_rx_active && (to_port == PORT);
    assign timer_inc = timer + ACK_W'(1);

    // armed is only set while the RX stream is idle, so parsing always starts
    // on the first byte of a packet, never mid-packet (e.g. after reset or TX).
    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            byte_idx        <= '0;
            seq_sh          <= '0;
            mac_sh          <= '0;
            ip_sh           <= '0;
            seq_valid       <= 1'b0;
            armed           <= 1'b0;
            sequence_number <= '0;
            seq_error       <= 1'b0;
            set_ip          <= 1'b0;
            assign_ip       <= '0;
            nconfig         <= 1'b0;
            pkt_count       <= '0;
            err_count       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge value of its neighbours, independent of statement order.
            seq_error <= 1'b0;
            if (!udp_rx_active)
                armed <= 1'b1;

            if (!accept) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (armed) begin
                        seq_sh   <= {seq_sh[23:0], udp_rx_data};
                        byte_idx <= 4'd1;
                        armed    <= 1'b0;
                        state    <= SEQ;
                    end
                    SEQ: begin
                        seq_sh   <= {seq_sh[23:0], udp_rx_data};
                        byte_idx <= byte_idx + 4'd1;
                        if (byte_idx == 4'd3)
                            state <= CMD;
                    end
                    CMD: begin
                        sequence_number <= seq_sh;
                        pkt_count       <= pkt_count + 16'd1;
                        seq_valid       <= 1'b1;
                        byte_idx        <= 4'd5;
                        if (SEQ_CHECK_EN && seq_valid &&
                            (seq_sh != sequence_number + 32'd1)) begin
                            seq_error <= 1'b1;
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                        end
                        if (udp_rx_data == 8'd2)
                            state <= DISCOVERY;
                        else if (udp_rx_data == 8'd3 && broadcast)
                            state <= SETIP;
                        else if (udp_rx_data == 8'd6 && !broadcast && RESET_CMD_EN)
                            state <= RESET;
                        else
                            state <= WAIT;
                    end
                    DISCOVERY: state <= TX;
                    TX: if (!sending_sync)
                        state <= IDLE;
                    SETIP: begin
                        byte_idx <= byte_idx + 4'd1;
                        if (byte_idx <= 4'd10) begin
                            mac_sh <= {mac_sh[39:0], udp_rx_data};
                        end else if (byte_idx == 4'd11 && mac_sh != local_mac) begin
                            state <= WAIT;
                        end else if (byte_idx == 4'd14) begin
                            assign_ip <= {ip_sh, udp_rx_data};
                            set_ip    <= 1'b1;
                            state     <= WAIT;
                        end else begin
                            ip_sh <= {ip_sh[15:0], udp_rx_data};
                        end
                    end
                    RESET: begin
                        nconfig <= 1'b1;
                        state   <= WAIT;
                    end
                    WAIT: state <= WAIT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The request drops on the edge where the timer would wrap to zero, giving
    // exactly 2^ACK_W-1 cycles of discovery_reply without an ACK.
    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            discovery_reply <= 1'b0;
            timer           <= '0;
        end else if (!discovery_reply) begin
            if (state == DISCOVERY) begin
                discovery_reply <= 1'b1;
                timer           <= ACK_W'(1);
            end
        end else if (discovery_ACK || timer_inc == '0) begin
            discovery_reply <= 1'b0;
        end else begin
            timer <= timer_inc;
        end
    end

endmodule

// File: tb/tb_sdr_cmd_receive.sv
// Self-checking bench for sdr_cmd_receive: a packet scoreboard checked on every
// pkt_count update plus per-scenario tasks for handshake, set-IP and reset.
module tb_sdr_cmd_receive;

    localparam logic [47:0] MAC = 48'h001C_C0A2_135D;

    logic        rx_clock = 1'b0;
    logic        reset_n;
    logic [7:0]  udp_rx_data;
    logic        udp_rx_active;
    logic [15:0] to_port;
    logic        broadcast;
    logic [47:0] local_mac;
    logic        sending_sync;
    logic        discovery_ACK;
    logic        discovery_reply;
    logic [31:0] sequence_number;
    logic        seq_error;
    logic        set_ip;
    logic [31:0] assign_ip;
    logic        nconfig;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    sdr_cmd_receive #(
        .PORT(16'd1024), .ACK_W(4), .RESET_CMD_EN(1'b1), .SEQ_CHECK_EN(1'b1)
    ) dut (
        .rx_clock(rx_clock), .reset_n(reset_n), .udp_rx_data(udp_rx_data),
        .udp_rx_active(udp_rx_active), .to_port(to_port), .broadcast(broadcast),
        .local_mac(local_mac), .sending_sync(sending_sync),
        .discovery_ACK(discovery_ACK), .discovery_reply(discovery_reply),
        .sequence_number(sequence_number), .seq_error(seq_error),
        .set_ip(set_ip), .assign_ip(assign_ip), .nconfig(nconfig),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 rx_clock = ~rx_clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] seq;
        logic        err;
        logic [15:0] pkt;
        logic [15:0] errc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_prev;
    bit          model_valid;
    logic [15:0] model_pkt;
    logic [15:0] model_err;

    function automatic void model_clear();
        model_prev  = '0;
        model_valid = 1'b0;
        model_pkt   = '0;
        model_err   = '0;
        exp_q.delete();
    endfunction

    // Reference sequence model: expected result of one accepted command byte.
    function automatic void push_expect(input logic [31:0] seq);
        exp_t e;
        e.err = model_valid && (seq != model_prev + 32'd1);
        if (e.err && model_err != 16'hFFFF)
            model_err = model_err + 16'd1;
        model_pkt   = model_pkt + 16'd1;
        model_prev  = seq;
        model_valid = 1'b1;
        e.seq  = seq;
        e.pkt  = model_pkt;
        e.errc = model_err;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor: every pkt_count update must match the next expectation;
    // seq_error may only be high on that same cycle.
    logic [15:0] last_pkt = '0;
    always @(negedge rx_clock) begin : monitor
        exp_t e;
        if (!reset_n) begin
            last_pkt = pkt_count;
        end else if (pkt_count !== last_pkt) begin
            last_pkt = pkt_count;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt: got pkt_count=%0d, want no update", pkt_count);
            end else begin
                e = exp_q.pop_front();
                checks += 3;
                if (sequence_number !== e.seq) begin
                    errors++;
                    $display("FAIL sb_seq: got %h want %h", sequence_number, e.seq);
                end
                if (seq_error !== e.err) begin
                    errors++;
                    $display("FAIL sb_seq_error: seq %h got %b want %b", e.seq, seq_error, e.err);
                end
                if (pkt_count !== e.pkt || err_count !== e.errc) begin
                    errors++;
                    $display("FAIL sb_counts: got pkt=%0d err=%0d want pkt=%0d err=%0d",
                             pkt_count, err_count, e.pkt, e.errc);
                end
            end
        end else begin
            checks++;
            if (seq_error !== 1'b0) begin
                errors++;
                $display("FAIL seq_error_stray: got %b want 0", seq_error);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        udp_rx_data   = b;
        udp_rx_active = 1'b1;
        @(posedge rx_clock);
        #1;
    endtask

    task automatic end_pkt();
        udp_rx_active = 1'b0;
        udp_rx_data   = '0;
        repeat (2) @(posedge rx_clock);
        #1;
    endtask

    task automatic send_hdr(input logic [31:0] seq, input logic [7:0] cmd);
        if (to_port == 16'd1024)
            push_expect(seq);
        for (int i = 3; i >= 0; i--)
            send_byte(seq[8*i +: 8]);
        send_byte(cmd);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        udp_rx_active = 1'b0;
        udp_rx_data   = '0;
        broadcast     = 1'b0;
        discovery_ACK = 1'b0;
        sending_sync  = 1'b0;
        repeat (2) @(posedge rx_clock);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge rx_clock);
        #1;
    endtask

    task automatic watch_reply(input bit do_ack, input int cycles,
                               output int high_cnt, output int rises);
        logic prev = 1'b0;
        high_cnt = 0;
        rises    = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge rx_clock);
            if (discovery_reply === 1'b1) begin
                if (!prev) rises++;
                high_cnt++;
            end
            prev = discovery_reply;
            discovery_ACK = do_ack && discovery_reply && (high_cnt == 3);
        end
        discovery_ACK = 1'b0;
    endtask

    task automatic test_reset();
        to_port   = 16'd1024;
        local_mac = MAC;
        do_reset();
        checks += 8;
        if (discovery_reply !== 1'b0) begin errors++; $display("FAIL rst_reply: got %b want 0", discovery_reply); end
        if (sequence_number !== 32'h0) begin errors++; $display("FAIL rst_seq: got %h want 0", sequence_number); end
        if (seq_error !== 1'b0) begin errors++; $display("FAIL rst_seq_error: got %b want 0", seq_error); end
        if (set_ip !== 1'b0) begin errors++; $display("FAIL rst_set_ip: got %b want 0", set_ip); end
        if (assign_ip !== 32'h0) begin errors++; $display("FAIL rst_assign_ip: got %h want 0", assign_ip); end
        if (nconfig !== 1'b0) begin errors++; $display("FAIL rst_nconfig: got %b want 0", nconfig); end
        if (pkt_count !== 16'h0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
        if (err_count !== 16'h0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_discovery_ack();
        int high_cnt, rises;
        fork
            begin
                send_hdr(32'h0000_0005, 8'd2);
                checks++;
                if (discovery_reply !== 1'b0) begin errors++; $display("FAIL disc_early: got %b want 0", discovery_reply); end
                send_byte(8'h00);
                checks++;
                if (discovery_reply !== 1'b1) begin errors++; $display("FAIL disc_rise: got %b want 1", discovery_reply); end
                send_byte(8'h00);
                end_pkt();
            end
            watch_reply(1'b1, 40, high_cnt, rises);
        join
        checks += 3;
        if (high_cnt != 3) begin errors++; $display("FAIL disc_ack_len: got %0d cycles want 3", high_cnt); end
        if (rises != 1) begin errors++; $display("FAIL disc_ack_rises: got %0d want 1", rises); end
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL disc_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_discovery_timeout();
        int high_cnt, rises;
        fork
            begin
                send_hdr(32'h0000_0006, 8'd2);
                send_byte(8'h00);
                end_pkt();
                send_hdr(32'h0000_0007, 8'd2);
                send_byte(8'h00);
                end_pkt();
            end
            watch_reply(1'b0, 60, high_cnt, rises);
        join
        checks += 2;
        if (high_cnt != 15) begin errors++; $display("FAIL disc_timeout_len: got %0d cycles want 15", high_cnt); end
        if (rises != 1) begin errors++; $display("FAIL disc_pending_rises: got %0d want 1", rises); end
    endtask

    task automatic send_setip(input logic [47:0] mac, input logic [31:0] ip,
                              input bit bcast, input int nbytes);
        logic [79:0] body;
        body      = {mac, ip};
        broadcast = bcast;
        send_hdr(model_prev + 32'd1, 8'd3);
        for (int i = 0; i < nbytes; i++)
            send_byte(body[79-8*i -: 8]);
        end_pkt();
        broadcast = 1'b0;
    endtask

    task automatic test_setip();
        logic [79:0] body;
        send_setip(MAC, 32'hC0A8_0164, 1'b0, 10);
        send_setip(MAC ^ 48'h1, 32'hC0A8_0164, 1'b1, 10);
        send_setip(MAC, 32'hC0A8_0164, 1'b1, 8);
        checks += 2;
        if (set_ip !== 1'b0) begin errors++; $display("FAIL setip_reject: got %b want 0", set_ip); end
        if (assign_ip !== 32'h0) begin errors++; $display("FAIL setip_reject_ip: got %h want 0", assign_ip); end

        body      = {MAC, 32'hC0A8_0164};
        broadcast = 1'b1;
        send_hdr(model_prev + 32'd1, 8'd3);
        for (int i = 0; i < 9; i++)
            send_byte(body[79-8*i -: 8]);
        checks++;
        if (set_ip !== 1'b0) begin errors++; $display("FAIL setip_before_b14: got %b want 0", set_ip); end
        send_byte(body[7:0]);
        checks += 2;
        if (set_ip !== 1'b1) begin errors++; $display("FAIL setip_commit: got %b want 1", set_ip); end
        if (assign_ip !== 32'hC0A8_0164) begin errors++; $display("FAIL setip_ip: got %h want c0a80164", assign_ip); end
        send_byte(8'h00);
        end_pkt();
        broadcast = 1'b0;

        send_setip(MAC, 32'hC0A8_0165, 1'b1, 10);
        checks += 2;
        if (set_ip !== 1'b1) begin errors++; $display("FAIL setip_sticky: got %b want 1", set_ip); end
        if (assign_ip !== 32'hC0A8_0165) begin errors++; $display("FAIL setip_overwrite: got %h want c0a80165", assign_ip); end
    endtask

    task automatic test_reset_cmd();
        to_port = 16'd1025;
        send_hdr(model_prev + 32'd1, 8'd6);
        send_byte(8'h00);
        end_pkt();
        send_hdr(32'h1234_5678, 8'd2);
        send_byte(8'h00);
        end_pkt();
        to_port = 16'd1024;
        checks += 4;
        if (nconfig !== 1'b0) begin errors++; $display("FAIL port_nconfig: got %b want 0", nconfig); end
        if (discovery_reply !== 1'b0) begin errors++; $display("FAIL port_reply: got %b want 0", discovery_reply); end
        if (pkt_count !== model_pkt) begin errors++; $display("FAIL port_pkt_count: got %0d want %0d", pkt_count, model_pkt); end
        if (sequence_number !== model_prev) begin errors++; $display("FAIL port_seq: got %h want %h", sequence_number, model_prev); end

        broadcast = 1'b1;
        send_hdr(model_prev + 32'd1, 8'd6);
        send_byte(8'h00);
        end_pkt();
        broadcast = 1'b0;
        checks++;
        if (nconfig !== 1'b0) begin errors++; $display("FAIL nconfig_bcast: got %b want 0", nconfig); end

        send_hdr(model_prev + 32'd1, 8'd6);
        send_byte(8'h00);
        end_pkt();
        checks++;
        if (nconfig !== 1'b1) begin errors++; $display("FAIL nconfig_unicast: got %b want 1", nconfig); end
    endtask

    task automatic test_reset_midpacket();
        logic [79:0] body;
        body      = {MAC, 32'hC0A8_0199};
        broadcast = 1'b1;
        send_hdr(model_prev + 32'd1, 8'd3);
        for (int i = 0; i < 8; i++)
            send_byte(body[79-8*i -: 8]);
        reset_n = 1'b0;
        model_clear();
        #1;
        checks += 6;
        if (set_ip !== 1'b0 || assign_ip !== 32'h0) begin errors++; $display("FAIL mid_rst_ip: got %b/%h want 0/0", set_ip, assign_ip); end
        if (nconfig !== 1'b0) begin errors++; $display("FAIL mid_rst_nconfig: got %b want 0", nconfig); end
        if (pkt_count !== 16'h0 || err_count !== 16'h0) begin errors++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", pkt_count, err_count); end
        if (sequence_number !== 32'h0) begin errors++; $display("FAIL mid_rst_seq: got %h want 0", sequence_number); end
        if (discovery_reply !== 1'b0) begin errors++; $display("FAIL mid_rst_reply: got %b want 0", discovery_reply); end
        if (seq_error !== 1'b0) begin errors++; $display("FAIL mid_rst_seq_error: got %b want 0", seq_error); end
        @(posedge rx_clock);
        #1;
        reset_n = 1'b1;
        for (int i = 8; i < 10; i++)
            send_byte(body[79-8*i -: 8]);
        for (int i = 0; i < 6; i++)
            send_byte(8'h02);
        end_pkt();
        broadcast = 1'b0;
        checks += 2;
        if (set_ip !== 1'b0) begin errors++; $display("FAIL mid_tail_set_ip: got %b want 0", set_ip); end
        if (pkt_count !== 16'h0) begin errors++; $display("FAIL mid_tail_pkt: got %0d want 0", pkt_count); end

        send_hdr(32'h0000_0009, 8'd4);
        send_byte(8'h00);
        end_pkt();
        checks += 2;
        if (pkt_count !== 16'd1 || err_count !== 16'd0) begin errors++; $display("FAIL post_rst_counts: got %0d/%0d want 1/0", pkt_count, err_count); end
        if (sequence_number !== 32'h9) begin errors++; $display("FAIL post_rst_seq: got %h want 9", sequence_number); end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] seqs [4];
        seqs = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0005};
        do_reset();
        foreach (seqs[i]) begin
            send_hdr(seqs[i], 8'd4);
            send_byte(8'h00);
            end_pkt();
        end
        checks += 3;
        if (err_count !== 16'd1) begin errors++; $display("FAIL wrap_err_count: got %0d want 1", err_count); end
        if (pkt_count !== 16'd4) begin errors++; $display("FAIL wrap_pkt_count: got %0d want 4", pkt_count); end
        if (sequence_number !== 32'h5) begin errors++; $display("FAIL wrap_seq: got %h want 5", sequence_number); end
    endtask

    initial begin
        test_reset();
        test_discovery_ack();
        test_discovery_timeout();
        test_setip();
        test_reset_cmd();
        test_reset_midpacket();
        test_seq_wrap();
        repeat (2) @(posedge rx_clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
